// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard path: set-2 scancodes, HID usages,
// decoder state encoding and the scancode-to-usage translation table.
package ps2_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

    // Bytes that follow E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77).
    localparam logic [2:0] PAUSE_TAIL_BYTES = 3'd7;

    typedef enum logic [2:0] {
        BASE,
        EXT,
        BRK,
        EXT_BRK,
        IGNORE
    } dec_state_e;

    typedef struct packed {
        logic       hit;
        logic [7:0] usage;
    } key_map_t;

    function automatic key_map_t map_scancode(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit   = 1'b1;
        m.usage = KC_NONE;
        if (!ext) begin
            case (code)
                SC_ENTER: m.usage = KC_ENTER;
                SC_W:     m.usage = KC_W;
                SC_S:     m.usage = KC_S;
                SC_A:     m.usage = KC_A;
                SC_D:     m.usage = KC_D;
                default:  m.hit   = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    m.usage = KC_UP;
                SC_DOWN:  m.usage = KC_DOWN;
                SC_LEFT:  m.usage = KC_LEFT;
                SC_RIGHT: m.usage = KC_RIGHT;
                default:  m.hit   = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the keyboard lines, shifts in 11-bit
// frames on PS2_Clk falling edges, checks parity/stop and drops stalled frames.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_error_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;

    // Synchronisers preset high so reset release never looks like a falling edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (fall) begin
            tmo_d = TMO_RELOAD;
            if (bit_cnt_q == 4'd0) begin
                if (!data_s) begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {data_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                parity_d  = data_s;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                bit_cnt_d = 4'd0;
                if (data_s && (^shift_q ^ parity_q)) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == '0) begin
                bit_cnt_d   = 4'd0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= TMO_RELOAD;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid_o  = byte_valid_q;
    assign byte_o        = byte_q;
    assign frame_error_o = frame_err_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 keyboard decoder: tracks E0/F0/E1 prefixes and presents the
// held game key as a HID usage with make/break event pulses.
module ps2_keycode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_Clk,
    input  logic       PS2_Data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       key_pressed,
    output logic       frame_error
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_frame_rx (
        .clk_i        (Clk),
        .rst_n_i      (Reset_n),
        .ps2_clk_i    (PS2_Clk),
        .ps2_data_i   (PS2_Data),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_error_o(rx_err)
    );

    dec_state_e state_q, state_d;
    logic [2:0] ign_q, ign_d;
    logic [7:0] keycode_q, keycode_d;
    logic       event_q, event_d;
    logic       pressed_q, pressed_d;

    logic       is_prefix;
    logic       do_decode;
    logic       is_ext;
    logic       is_make;
    key_map_t   map;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= BASE;
            ign_q     <= 3'd0;
            keycode_q <= KC_NONE;
            event_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ign_q     <= ign_d;
            keycode_q <= keycode_d;
            event_q   <= event_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ign_d   = ign_q;
        if (rx_err) begin
            state_d = BASE;
            ign_d   = 3'd0;
        end else if (rx_valid) begin
            case (state_q)
                BASE: begin
                    if (rx_byte == SC_E0) begin
                        state_d = EXT;
                    end else if (rx_byte == SC_F0) begin
                        state_d = BRK;
                    end else if (rx_byte == SC_E1) begin
                        state_d = IGNORE;
                        ign_d   = PAUSE_TAIL_BYTES;
                    end
                end
                EXT:     state_d = (rx_byte == SC_F0) ? EXT_BRK : BASE;
                BRK:     state_d = BASE;
                EXT_BRK: state_d = BASE;
                IGNORE: begin
                    ign_d = ign_q - 3'd1;
                    if (ign_q <= 3'd1) begin
                        state_d = BASE;
                    end
                end
                default: state_d = BASE;
            endcase
        end
    end

    // Prefix bytes only steer the FSM; every other byte in a non-IGNORE state is a key code.
    always_comb begin
        is_prefix = (rx_byte == SC_E0) || (rx_byte == SC_F0) || (rx_byte == SC_E1);
        do_decode = 1'b0;
        if (rx_valid) begin
            case (state_q)
                BASE:    do_decode = !is_prefix;
                EXT:     do_decode = (rx_byte != SC_F0);
                BRK:     do_decode = 1'b1;
                EXT_BRK: do_decode = 1'b1;
                default: do_decode = 1'b0;
            endcase
        end
        is_ext  = (state_q == EXT) || (state_q == EXT_BRK);
        is_make = (state_q == BASE) || (state_q == EXT);
        map     = map_scancode(is_ext, rx_byte);

        keycode_d = keycode_q;
        event_d   = 1'b0;
        pressed_d = pressed_q;
        if (do_decode && map.hit) begin
            event_d = 1'b1;
            if (is_make) begin
                keycode_d = map.usage;
                pressed_d = 1'b1;
            end else begin
                pressed_d = 1'b0;
                if (keycode_q == map.usage) begin
                    keycode_d = KC_NONE;
                end
            end
        end
    end

    assign keycode     = keycode_q;
    assign key_event   = event_q;
    assign key_pressed = pressed_q;
    assign frame_error = rx_err;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder: a table of single frames with
// expected outputs, plus latency, timeout and async-reset sequences.
module tb_ps2_keycode_decoder;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 50000;
    localparam int SYNC    = 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       PS2_Clk = 1'b1;
    logic       PS2_Data = 1'b1;
    logic [7:0] keycode;
    logic       key_event;
    logic       key_pressed;
    logic       frame_error;

    ps2_keycode_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .PS2_Clk    (PS2_Clk),
        .PS2_Data   (PS2_Data),
        .keycode    (keycode),
        .key_event  (key_event),
        .key_pressed(key_pressed),
        .frame_error(frame_error)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int ev_cnt = 0, fe_cnt = 0, ev_long = 0, fe_long = 0;
    int last_ev_cyc = 0, last_fe_cyc = 0;
    logic ev_prev = 1'b0, fe_prev = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (key_event) begin
            ev_cnt++;
            last_ev_cyc = cyc;
            if (ev_prev) ev_long++;
        end
        if (frame_error) begin
            fe_cnt++;
            last_fe_cyc = cyc;
            if (fe_prev) fe_long++;
        end
        ev_prev = key_event;
        fe_prev = frame_error;
    end

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] kc;
        int         ev;
        logic       pr;
        int         fe;
    } vec_t;

    localparam int NV = 39;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge Clk);
            PS2_Data = f[i];
            repeat (HALF) @(negedge Clk);
            PS2_Clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge Clk);
            PS2_Clk = 1'b1;
        end
        repeat (HALF) @(negedge Clk);
        PS2_Data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_bits(mk_frame(b, 1'b0, 1'b0), 11);
        @(posedge Clk);
    endtask

    initial begin
        int ev0, fe0, lat;

        vecs[0]  = '{8'hF0, 1'b0, 1'b0, 8'h28, 0, 1'b1, 0};
        vecs[1]  = '{8'h5A, 1'b0, 1'b0, 8'h00, 1, 1'b0, 0};
        vecs[2]  = '{8'h15, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 8'h52, 1, 1'b1, 0};
        vecs[5]  = '{8'h1D, 1'b0, 1'b0, 8'h1A, 1, 1'b1, 0};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 8'h1A, 0, 1'b1, 0};
        vecs[7]  = '{8'hF0, 1'b0, 1'b0, 8'h1A, 0, 1'b1, 0};
        vecs[8]  = '{8'h75, 1'b0, 1'b0, 8'h1A, 1, 1'b0, 0};
        vecs[9]  = '{8'h5A, 1'b1, 1'b0, 8'h1A, 0, 1'b0, 1};
        vecs[10] = '{8'h1B, 1'b0, 1'b0, 8'h16, 1, 1'b1, 0};
        vecs[11] = '{8'h1B, 1'b0, 1'b0, 8'h16, 1, 1'b1, 0};
        vecs[12] = '{8'h23, 1'b0, 1'b1, 8'h16, 0, 1'b1, 1};
        vecs[13] = '{8'hE0, 1'b0, 1'b0, 8'h16, 0, 1'b1, 0};
        vecs[14] = '{8'hF0, 1'b1, 1'b0, 8'h16, 0, 1'b1, 1};
        vecs[15] = '{8'h75, 1'b0, 1'b0, 8'h16, 0, 1'b1, 0};
        vecs[16] = '{8'hF0, 1'b0, 1'b0, 8'h16, 0, 1'b1, 0};
        vecs[17] = '{8'h1B, 1'b0, 1'b0, 8'h00, 1, 1'b0, 0};
        vecs[18] = '{8'hE1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
        for (int k = 19; k <= 25; k++) vecs[k] = '{8'h1D, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
        vecs[26] = '{8'h1D, 1'b0, 1'b0, 8'h1A, 1, 1'b1, 0};
        vecs[27] = '{8'hE0, 1'b0, 1'b0, 8'h1A, 0, 1'b1, 0};
        vecs[28] = '{8'h74, 1'b0, 1'b0, 8'h4F, 1, 1'b1, 0};
        vecs[29] = '{8'hE0, 1'b0, 1'b0, 8'h4F, 0, 1'b1, 0};
        vecs[30] = '{8'h72, 1'b0, 1'b0, 8'h51, 1, 1'b1, 0};
        vecs[31] = '{8'hE0, 1'b0, 1'b0, 8'h51, 0, 1'b1, 0};
        vecs[32] = '{8'h6B, 1'b0, 1'b0, 8'h50, 1, 1'b1, 0};
        vecs[33] = '{8'hF0, 1'b0, 1'b0, 8'h50, 0, 1'b1, 0};
        vecs[34] = '{8'h1D, 1'b0, 1'b0, 8'h50, 1, 1'b0, 0};
        vecs[35] = '{8'h1C, 1'b0, 1'b0, 8'h04, 1, 1'b1, 0};
        vecs[36] = '{8'h23, 1'b0, 1'b0, 8'h07, 1, 1'b1, 0};
        vecs[37] = '{8'hF0, 1'b0, 1'b0, 8'h07, 0, 1'b1, 0};
        vecs[38] = '{8'h23, 1'b0, 1'b0, 8'h00, 1, 1'b0, 0};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst keycode", keycode, 8'h00);
        chk("rst key_event", key_event, 1'b0);
        chk("rst key_pressed", key_pressed, 1'b0);
        chk("rst frame_error", frame_error, 1'b0);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        // Enter make with latency from the stop-bit edge
        ev0 = ev_cnt;
        send(8'h5A);
        #1;
        chk("t1 keycode", keycode, 8'h28);
        chk("t1 key_pressed", key_pressed, 1'b1);
        chk("t1 events", ev_cnt - ev0, 1);
        lat = last_ev_cyc - last_fall_cyc;
        chk_range("t1 latency", lat, 1, SYNC + 3);

        for (int i = 0; i < NV; i++) begin
            ev0 = ev_cnt;
            fe0 = fe_cnt;
            ps2_bits(mk_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop), 11);
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d keycode", i), keycode, vecs[i].kc);
            chk($sformatf("vec%0d events", i), ev_cnt - ev0, vecs[i].ev);
            chk($sformatf("vec%0d key_pressed", i), key_pressed, vecs[i].pr);
            chk($sformatf("vec%0d frame_errors", i), fe_cnt - fe0, vecs[i].fe);
        end

        // Stalled partial frame, then a clean frame must still align
        fe0 = fe_cnt;
        ps2_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
        for (int i = 0; i < TIMEOUT + 100; i++) begin
            @(posedge Clk);
            if (fe_cnt != fe0) break;
        end
        #1;
        chk("tmo frame_errors", fe_cnt - fe0, 1);
        chk_range("tmo delay", last_fe_cyc - last_fall_cyc, TIMEOUT, TIMEOUT + SYNC + 4);
        chk("tmo keycode kept", keycode, 8'h00);
        ev0 = ev_cnt;
        fe0 = fe_cnt;
        send(8'h1C);
        #1;
        chk("post-tmo keycode", keycode, 8'h04);
        chk("post-tmo events", ev_cnt - ev0, 1);
        chk("post-tmo frame_errors", fe_cnt - fe0, 0);

        // Async reset mid-frame clears keycode and the pending break prefix
        send(8'h5A);
        #1;
        chk("pre-rst keycode", keycode, 8'h28);
        send(8'hE0);
        send(8'hF0);
        ps2_bits(mk_frame(8'h23, 1'b0, 1'b0), 5);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async rst keycode", keycode, 8'h00);
        chk("async rst key_pressed", key_pressed, 1'b0);
        repeat (3) @(negedge Clk);
        PS2_Clk  = 1'b1;
        PS2_Data = 1'b1;
        Reset_n  = 1'b1;
        repeat (5) @(negedge Clk);
        ev0 = ev_cnt;
        send(8'h23);
        #1;
        chk("post-rst keycode", keycode, 8'h07);
        chk("post-rst key_pressed", key_pressed, 1'b1);
        chk("post-rst events", ev_cnt - ev0, 1);

        chk("key_event pulse width", ev_long, 0);
        chk("frame_error pulse width", fe_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
